// File: rtl/vec_mem_sequencer.sv
// Vector memory sequencer: splits 128-bit vector loads/stores into four 32-bit
// RAM beats, reassembles load data and stalls the pipeline while busy.
module vec_mem_sequencer #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
  output logic              rsp_valid,
  output logic [127:0]      rsp_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned VEC_W  = 128;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned ASM_W  = 96;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [VEC_W-1:0]    wdata_q, wdata_d;
  logic [ASM_W-1:0]    asm_q, asm_d;
  logic [VEC_W-1:0]    rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [BEAT_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                accept;

  assign req_ready = reset & ((state_q == IDLE) | (state_q == RESP));
  assign accept    = req_valid & req_ready;
  assign stall     = reset & (accept | (state_q == ISSUE) | (state_q == DRAIN));
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state and next-register logic; RAM port registers are loaded one
  // cycle ahead so beat k appears while the FSM sits in ISSUE with k.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    we_d        = we_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          state_d    = ISSUE;
          k_d        = 2'd0;
          we_d       = req_we;
          base_d     = req_addr & ~ADDR_W'(3);
          wdata_d    = req_wdata;
          mem_addr_d = req_addr & ~ADDR_W'(3);
          mem_we_d   = req_we;
          if (req_we) mem_wdata_d = req_wdata[BEAT_W-1:0];
        end
      end
      ISSUE: begin
        // Read data for the previous beat arrives this cycle
        if (!we_q) begin
          case (k_q)
            2'd1:    asm_d[31:0]  = mem_rdata;
            2'd2:    asm_d[63:32] = mem_rdata;
            2'd3:    asm_d[95:64] = mem_rdata;
            default: ;
          endcase
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = we_q ? RESP : DRAIN;
        end else begin
          mem_addr_d = base_q | ADDR_W'(k_d);
          mem_we_d   = we_q;
          if (we_q) mem_wdata_d = wdata_q[{k_d, 5'b00000} +: BEAT_W];
        end
      end
      DRAIN: begin
        rdata_d = {mem_rdata, asm_q};
        state_d = RESP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      we_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      we_q        <= we_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a behavioural 1-cycle-latency RAM.
module tb_vec_mem_sequencer;

  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [127:0]      req_wdata;
  logic              rsp_valid;
  logic [127:0]      rsp_rdata;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] ram [0:(1<<ADDR_W)-1];
  int wr_cnt  = 0;
  int rsp_cnt = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vec_mem_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM model: synchronous write, read data one cycle after address
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= ram[mem_addr];
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 16'h1234; req_wdata = '1;
    next_cycle(); next_cycle();
    @(negedge clk);
    n_checks++;
    if ({req_ready, stall, rsp_valid, mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {req_ready, stall, rsp_valid, mem_we});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h wdata %h rdata %h expected zeros", mem_addr, mem_wdata, rsp_rdata);
    end
    next_cycle();
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got ready/stall %b expected 10", {req_ready, stall});
    end
    next_cycle();
  endtask

  task automatic test_store();
    logic [127:0] wd;
    logic [31:0]  w;
    wd = 128'h33333333_22222222_11111111_00000000;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0011; req_wdata = wd;
    @(negedge clk);
    n_checks++;
    if ({req_ready, stall, rsp_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL store_accept: got %b expected 110", {req_ready, stall, rsp_valid});
    end
    next_cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w = wd[32*i +: 32];
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, stall, rsp_valid} !== {1'b1, 16'h0010 + 16'(i), w, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL store_beat%0d: got we %b addr %h data %h stall %b rv %b expected we 1 addr %h data %h stall 1 rv 0",
                 i, mem_we, mem_addr, mem_wdata, stall, rsp_valid, 16'h0010 + 16'(i), w);
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, stall, mem_we} !== 3'b100) begin
      n_fail++;
      $display("FAIL store_resp: got rv/stall/we %b expected 100", {rsp_valid, stall, mem_we});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL store_resp_pulse: got rsp_valid %b expected 0", rsp_valid);
    end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      w = wd[32*i +: 32];
      n_checks++;
      if (ram[16'h0010 + 16'(i)] !== w) begin
        n_fail++;
        $display("FAIL store_ram%0d: got %h expected %h", i, ram[16'h0010 + 16'(i)], w);
      end
    end
  endtask

  task automatic test_load();
    logic [127:0] exp_v;
    logic [127:0] wd2;
    exp_v = 128'h33333333_22222222_11111111_00000000;
    wd2   = 128'h77777777_66666666_55555555_44444444;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, stall, mem_we} !== {(c == 6), (c <= 5), 1'b0}) begin
        n_fail++;
        $display("FAIL load_ctrl_c%0d: got rv/stall/we %b expected %b", c, {rsp_valid, stall, mem_we}, {(c == 6), (c <= 5), 1'b0});
      end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (mem_addr !== 16'h0010 + 16'(c - 1)) begin
          n_fail++;
          $display("FAIL load_addr_c%0d: got %h expected %h", c, mem_addr, 16'h0010 + 16'(c - 1));
        end
      end
      if (c == 6) begin
        n_checks++;
        if (rsp_rdata !== exp_v) begin
          n_fail++;
          $display("FAIL load_rdata: got %h expected %h", rsp_rdata, exp_v);
        end
      end
      next_cycle();
    end
    // A store must leave the returned load vector alone
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = wd2;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp_rdata !== exp_v) begin
        n_fail++;
        $display("FAIL load_hold_c%0d: got %h expected %h", c, rsp_rdata, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    for (int c = 0; c < 14; c++) begin
      if (c == 6) req_addr = 16'h0020;
      if (c == 7) req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, stall} !== {(c == 6 || c == 12), (c < 12)}) begin
        n_fail++;
        $display("FAIL b2b_ctrl_c%0d: got rv/stall %b expected %b", c, {rsp_valid, stall}, {(c == 6 || c == 12), (c < 12)});
      end
      if (c >= 1 && c <= 4) begin
        n_checks++;
        if (mem_addr !== 16'h0010 + 16'(c - 1)) begin
          n_fail++;
          $display("FAIL b2b_addr_c%0d: got %h expected %h", c, mem_addr, 16'h0010 + 16'(c - 1));
        end
      end
      if (c >= 7 && c <= 10) begin
        n_checks++;
        if (mem_addr !== 16'h0020 + 16'(c - 7)) begin
          n_fail++;
          $display("FAIL b2b_addr_c%0d: got %h expected %h", c, mem_addr, 16'h0020 + 16'(c - 7));
        end
      end
      if (c == 12) begin
        n_checks++;
        if (rsp_rdata !== 128'h77777777_66666666_55555555_44444444) begin
          n_fail++;
          $display("FAIL b2b_rdata: got %h expected 77777777666666665555555544444444", rsp_rdata);
        end
      end
      next_cycle();
    end
    n_checks++;
    if (rsp_cnt - r0 !== 2) begin
      n_fail++;
      $display("FAIL b2b_rsp_count: got %0d expected 2", rsp_cnt - r0);
    end
  endtask

  task automatic test_ignore_mid();
    int w0, r0;
    w0 = wr_cnt; r0 = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0030;
    req_wdata = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) req_valid = 1'b0;
      if (c == 2) begin
        req_valid = 1'b1; req_addr = 16'h0040; req_wdata = '1;
      end
      if (c == 3) req_valid = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        n_checks++;
        if ({req_ready, stall} !== 2'b01) begin
          n_fail++;
          $display("FAIL ignore_ready: got ready/stall %b expected 01", {req_ready, stall});
        end
      end
      next_cycle();
    end
    n_checks++;
    if (wr_cnt - w0 !== 4) begin
      n_fail++;
      $display("FAIL ignore_beats: got %0d writes expected 4", wr_cnt - w0);
    end
    n_checks++;
    if (rsp_cnt - r0 !== 1) begin
      n_fail++;
      $display("FAIL ignore_rsp: got %0d responses expected 1", rsp_cnt - r0);
    end
    n_checks++;
    if ({ram[16'h0033], ram[16'h0040]} !== {32'hAAAA0003, 32'hC0DE0040}) begin
      n_fail++;
      $display("FAIL ignore_ram: got %h %h expected aaaa0003 c0de0040", ram[16'h0033], ram[16'h0040]);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0050;
    req_wdata = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    reset = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, stall, mem_we, mem_addr} !== {3'b001, 16'h0051}) begin
      n_fail++;
      $display("FAIL rstmid_low: got ready/stall/we %b addr %h expected 001 0051", {req_ready, stall, mem_we}, mem_addr);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({mem_we, rsp_valid, req_ready, stall, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got we %b rv %b addr %h wdata %h rdata %h expected zeros",
               mem_we, rsp_valid, mem_addr, mem_wdata, rsp_rdata);
    end
    next_cycle();
    reset = 1'b1; req_valid = 1'b0;
    for (int c = 0; c < 6; c++) next_cycle();
    @(negedge clk);
    n_checks++;
    if ({req_ready, stall, mem_we} !== 3'b100 || rsp_cnt - r0 !== 0) begin
      n_fail++;
      $display("FAIL rstmid_idle: got ready/stall/we %b rsp %0d expected 100 rsp 0", {req_ready, stall, mem_we}, rsp_cnt - r0);
    end
    n_checks++;
    if ({ram[16'h0050], ram[16'h0051], ram[16'h0052], ram[16'h0053]} !==
        {32'hDDDD0000, 32'hDDDD0001, 32'hC0DE0052, 32'hC0DE0053}) begin
      n_fail++;
      $display("FAIL rstmid_ram: got %h %h %h %h expected dddd0000 dddd0001 c0de0052 c0de0053",
               ram[16'h0050], ram[16'h0051], ram[16'h0052], ram[16'h0053]);
    end
    next_cycle();
  endtask

  task automatic test_max_addr();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hFFFE;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) req_valid = 1'b0;
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        n_checks++;
        if (mem_addr !== 16'hFFFC + 16'((c > 4) ? 3 : c - 1)) begin
          n_fail++;
          $display("FAIL max_addr_c%0d: got %h expected %h", c, mem_addr, 16'hFFFC + 16'((c > 4) ? 3 : c - 1));
        end
      end
      if (c == 6) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 128'hC0DEFFFF_C0DEFFFE_C0DEFFFD_C0DEFFFC) begin
          n_fail++;
          $display("FAIL max_rdata: got rv %b data %h expected rv 1 data c0deffffc0defffec0defffdc0defffc", rsp_valid, rsp_rdata);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 32'hC0DE0000 | 32'(i);
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_ignore_mid();
    test_reset_mid();
    test_max_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
# vec_mem_sequencer

Sequencer between the pipeline's vector memory stage and the single-port 32-bit sample RAM. It accepts one 128-bit vector load or store per request (16 lanes × 8 bit, lane 0 in bits 7:0). It splits each request into four 32-bit RAM beats and reassembles load data into the 128-bit word returned as `q_b`. It also raises `stall` to the hazard unit while a transfer is in flight.

## Interface

Parameters:
- `ADDR_W`, default 16: RAM word-address width (32-bit words).

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `req_valid`, input, 1: vector request present.
- `req_ready`, output, 1: request accepted on a cycle where `req_valid & req_ready`.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, ADDR_W: word address; bits [1:0] ignored, so the base is 4-word aligned.
- `req_wdata`, input, 128: store data (`data_b` from the datapath).
- `rsp_valid`, output, 1: one-cycle completion pulse for both loads and stores.
- `rsp_rdata`, output, 128: assembled load vector (`q_b`); registered and held.
- `stall`, output, 1: pipeline stall request to the hazard unit.
- `mem_addr`, output, ADDR_W: RAM address.
- `mem_we`, output, 1: RAM write enable.
- `mem_wdata`, output, 32: RAM write data.
- `mem_rdata`, input, 32: RAM read data, valid the cycle after its address is presented.

## Operation

- States:
  - IDLE: no transfer in flight.
  - ISSUE: 2-bit beat counter `k`, values 0..3.
  - DRAIN: loads only.
  - RESP.
- Acceptance:
  - `req_ready = reset & (state==IDLE | state==RESP)`.
  - On accept, latch `req_we`, base `{req_addr[ADDR_W-1:2],2'b00}` and `req_wdata`; go to ISSUE with `k=0`.
  - `req_valid` while not ready is ignored; nothing is queued.
- ISSUE, beat k:
  - `mem_addr = base + k`.
  - Store: `mem_we=1`, `mem_wdata = wdata[32k+31:32k]`.
  - Load: `mem_we=0`.
  - Increment `k`. After `k=3`, a store goes to RESP and a load goes to DRAIN.
- Load capture:
  - `mem_rdata` sampled in the cycle after beat k is written into the assembly register bits [32k+31:32k].
  - DRAIN captures beat 3, then goes to RESP.
- RESP:
  - `rsp_valid=1` for exactly one cycle.
  - On a load, `rsp_rdata` takes the assembled vector at the edge entering RESP.
  - On a store, `rsp_rdata` is unchanged.
  - Next state is ISSUE if a request is accepted in this cycle, otherwise IDLE.
- `stall = (req_valid & req_ready) | state==ISSUE | state==DRAIN`. It is low in RESP unless a new request is accepted.
- Outside ISSUE: `mem_we=0`, while `mem_addr` and `mem_wdata` hold their last values.
- Address arithmetic is ADDR_W-bit. Base+3 never crosses the aligned block, so there is no wrap.
- Reset (`reset=0` at an edge):
  - state=IDLE, `k=0`, `rsp_valid=0`, `rsp_rdata=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - Any in-flight transfer is abandoned with no response; partial store beats already written remain in RAM.
  - `req_ready=0` and `stall=0` while `reset` is low.

## Timing

- Request accepted in cycle T.
- Store:
  - Beats 0..3 on the RAM port in T+1..T+4 (`mem_we=1`).
  - `rsp_valid` in T+5.
  - `stall` high T..T+4.
- Load:
  - Addresses in T+1..T+4; data captured at the ends of T+2..T+5.
  - DRAIN is T+5; `rsp_valid` and the new `rsp_rdata` appear in T+6.
  - `stall` high T..T+5.
- Back-to-back: a request accepted in the RESP cycle R issues its beat 0 at R+1. No idle cycle; RAM throughput is 4 beats per store with a 1-cycle gap.
- All outputs except `req_ready` and `stall` are registered or decoded from registers only. `req_ready` and `stall` are combinational from `req_valid`, `reset` and state.

## Test plan

- Store, `req_addr=0x0011` (base 0x0010), `wdata=0x33333333_22222222_11111111_00000000`:
  - writes 0x00000000@0x10, 0x11111111@0x11, 0x22222222@0x12, 0x33333333@0x13 in T+1..T+4;
  - `rsp_valid` in T+5; `stall` high T..T+4.
- Load from base 0x0010 after the store above:
  - `rsp_valid` in T+6 with `rsp_rdata=0x33333333_22222222_11111111_00000000`;
  - `stall` high T..T+5;
  - `rsp_rdata` holds through a later store.
- Load with `req_valid` held high through RESP:
  - the second load is accepted in RESP, and its `mem_addr` beat 0 appears at RESP+1;
  - `rsp_valid` is exactly one cycle per request.
- `req_valid` pulsed mid-transfer in ISSUE:
  - ignored; only one `rsp_valid`; the RAM sees no extra beats.
- `reset` low at beat 2 of a store:
  - next cycle `mem_we=0`, state IDLE, no `rsp_valid`;
  - words at base+0 and base+1 are written and base+2/+3 are untouched;
  - `rsp_rdata=0`.
- Load at `ADDR_W` maximum base 0xFFFC:
  - addresses 0xFFFC..0xFFFF, with no wrap into 0x0000.
